ram_uart_dump: RTL and testbench
================================

# ram_uart_dump

Post-execution result dumper on the CPU's RAM side. Once the CPU signals completion on its RAM-read/UART enable output, this block reads data RAM word by word from address 0 and serialises each word onto an 8N1 UART transmit line for the host. It owns the RAM read port while dumping and is the UART consumer of the CPU's `enable_ram_read` output.

## Interface

Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- `ADDR_WIDTH`, 6: RAM address width.
- `DATA_WIDTH`, 16: RAM word width; fixed at 16 for this block.
- `DUMP_DEPTH`, 64: number of words dumped, addresses 0..`DUMP_DEPTH`-1; legal range 1..2^`ADDR_WIDTH`.

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: dump request, driven from the CPU's `enable_ram_read`; level-sensitive.
- `ram_addr` out `ADDR_WIDTH`: RAM read address.
- `ram_rd_en` out 1: RAM read enable, one-cycle pulse per word.
- `ram_data` in 16: RAM read data, valid the cycle after `ram_rd_en`.
- `tx` out 1: UART serial output; idle high.
- `busy` out 1: high from leaving IDLE until entering DONE.
- `done` out 1: high while in DONE.

## Operation

- States:
  - IDLE
  - READ: `ram_rd_en`=1 for this cycle.
  - LATCH: capture `ram_data` into the word register.
  - LOAD: select the next byte into the shift register.
  - START: `tx`=0.
  - DATA: 8 bits, LSB first.
  - STOP: `tx`=1.
  - DONE
- Transitions:
  - IDLE→READ when `start`=1.
  - READ→LATCH→LOAD→START→DATA→STOP.
  - STOP→LOAD if bytes remain in the word.
  - STOP→READ if words remain; the address increments on this transition.
  - STOP→DONE after the final byte of word `DUMP_DEPTH`-1.
  - DONE→IDLE only when `start`=0. Holding `start`=1 produces exactly one dump per reset.
- Raw byte order: 2 bytes per word, `ram_data[15:8]` first, then `[7:0]`.
- `start` is ignored outside IDLE and DONE. Deasserting it mid-dump does not abort the dump.
- `ram_addr` counts 0..`DUMP_DEPTH`-1 and never wraps. With `DUMP_DEPTH`=2^`ADDR_WIDTH`, the final address is all-ones and the block enters DONE with no further read.
- `ram_data` is sampled only in LATCH. Changes at any other time have no effect.
- Reset values: `tx`=1, `ram_rd_en`=0, `ram_addr`=0, `busy`=0, `done`=0. State returns to IDLE and the bit counter and baud counter clear.
- Reset mid-frame: `tx`=1 on the cycle after reset is sampled low. The dump restarts from address 0 on the next `start`.

## Timing

- Let `start` be sampled high in IDLE at cycle N. Then:
  - `ram_rd_en`=1 at N+1.
  - LATCH at N+2.
  - LOAD at N+3.
  - `tx` falls (start bit) at N+4.
- Each bit is exactly `CLKS_PER_BIT` cycles, so a frame is 10·`CLKS_PER_BIT` cycles.
- Gap between bytes of the same word: 1 cycle (LOAD) with `tx`=1.
- Gap between words: 3 cycles (READ, LATCH, LOAD) with `tx`=1.
- `done` rises on the cycle after the last stop bit completes. `busy` falls on the same cycle.

## Configuration

- `RAM_DUMP_HEX_EN` defined: each word is sent as 6 ASCII bytes.
  - Four upper-case hex digits, most significant nibble first: '0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46.
  - Followed by 0x0D, then 0x0A.
  - Per-byte timing and inter-byte gaps are unchanged.
- Undefined: 2 raw bytes per word, as described above. No hex-encoding logic is synthesised.

## Test plan

Benches run with `CLKS_PER_BIT`=4.

- Reset: hold `reset`=0 with `start`=1 for 3 cycles → `tx`=1, `busy`=0, `done`=0, `ram_rd_en`=0, `ram_addr`=0 throughout.
- Raw single word: `DUMP_DEPTH`=1, RAM[0]=16'hA55A, `start`=1 at N → `ram_rd_en` at N+1; `tx` frames 0xA5 then 0x5A, LSB first; `done`=1 at N+4+80+1 and held while `start`=1.
- Hex mode (`RAM_DUMP_HEX_EN` defined): RAM[0]=16'h00F3 → bytes 0x30, 0x30, 0x46, 0x33, 0x0D, 0x0A.
- Full sweep: `DUMP_DEPTH`=64, RAM[i]=i → exactly 64 `ram_rd_en` pulses with addresses 0..63 in order; 128 frames; no re-read of address 0.
- Reset mid-frame: assert `reset`=0 during the DATA bits of word 3 → `tx`=1 next cycle; after release, the dump restarts at address 0.
- Re-arm: after DONE, drive `start` 1→0→1 → a second complete dump. Toggling `start` during a dump → no effect.

Source files
------------

// File: rtl/ram_uart_dump.sv
// ram_uart_dump: once `start` is seen in IDLE, reads data RAM words
// 0..DUMP_DEPTH-1 and sends each one as 8N1 UART frames on `tx`.
//
// State table:
//   IDLE  | waiting for start
//   READ  | ram_rd_en pulse for the current address
//   LATCH | capture ram_data into the word register
//   LOAD  | select the next byte of the word into the shift register
//   START | start bit (tx=0)
//   DATA  | 8 data bits, LSB first
//   STOP  | stop bit (tx=1)
//   DONE  | dump finished; waits for start=0 before re-arming
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-low reset
//   start     in   level-sensitive dump request
//   ram_addr  out  RAM read address
//   ram_rd_en out  one-cycle read strobe per word
//   ram_data  in   RAM read data, valid the cycle after ram_rd_en
//   tx        out  UART line, idle high
//   busy      out  dump in progress
//   done      out  high while in DONE
//
// Build option: define RAM_DUMP_HEX_EN to send each word as four upper-case
// hex digits followed by CR LF; otherwise two raw bytes, high byte first.
module ram_uart_dump #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 16,
  parameter int DUMP_DEPTH   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_rd_en,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

`ifdef RAM_DUMP_HEX_EN
  localparam int BYTES_PER_WORD = 6;
`else
  localparam int BYTES_PER_WORD = 2;
`endif
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0]     BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DUMP_DEPTH - 1);
  localparam logic [2:0]            LAST_BYTE = 3'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    IDLE, READ, LATCH, LOAD, START, DATA, STOP, DONE
  } state_t;

  state_t                state, state_nx;
  logic [BAUD_W-1:0]     baud_cnt;
  logic                  baud_tc;
  logic [2:0]            bit_cnt;
  logic [2:0]            byte_idx;
  logic [DATA_WIDTH-1:0] word;
  logic [7:0]            shreg;
  logic [7:0]            next_byte;

  assign baud_tc = (baud_cnt == '0);

`ifdef RAM_DUMP_HEX_EN
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    // 'A' - 10 = 0x37
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  always_comb begin
    next_byte = 8'h0A;
    case (byte_idx)
      3'd0:    next_byte = hex_ascii(word[15:12]);
      3'd1:    next_byte = hex_ascii(word[11:8]);
      3'd2:    next_byte = hex_ascii(word[7:4]);
      3'd3:    next_byte = hex_ascii(word[3:0]);
      3'd4:    next_byte = 8'h0D;
      default: next_byte = 8'h0A;
    endcase
  end
`else
  always_comb begin
    next_byte = (byte_idx == 3'd0) ? word[15:8] : word[7:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    ram_rd_en = 1'b0;
    tx        = 1'b1;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = READ;
      end
      READ: begin
        ram_rd_en = 1'b1;
        state_nx  = LATCH;
      end
      LATCH: state_nx = LOAD;
      LOAD:  state_nx = START;
      START: begin
        tx = 1'b0;
        if (baud_tc) state_nx = DATA;
      end
      DATA: begin
        tx = shreg[0];
        if (baud_tc && bit_cnt == 3'd7) state_nx = STOP;
      end
      STOP: begin
        if (baud_tc) begin
          if (byte_idx != LAST_BYTE)      state_nx = LOAD;
          else if (ram_addr != LAST_ADDR) state_nx = READ;
          else                            state_nx = DONE;
        end
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (!start) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      ram_addr <= '0;
      word     <= '0;
      shreg    <= '1;
    end else begin
      // Down-counter runs only inside a bit; everywhere else it sits preloaded
      // so the first bit of every frame gets its full CLKS_PER_BIT cycles.
      if ((state == START || state == DATA || state == STOP) && !baud_tc)
        baud_cnt <= baud_cnt - 1'b1;
      else
        baud_cnt <= BAUD_LOAD;

      if (state == DATA) begin
        if (baud_tc) begin
          bit_cnt <= bit_cnt + 3'd1;
          shreg   <= {1'b1, shreg[7:1]};
        end
      end else begin
        bit_cnt <= '0;
      end

      case (state)
        IDLE:  ram_addr <= '0;
        READ:  byte_idx <= '0;
        LATCH: word     <= ram_data;
        LOAD:  shreg    <= next_byte;
        STOP: begin
          if (state_nx == LOAD) byte_idx <= byte_idx + 3'd1;
          if (state_nx == READ) ram_addr <= ram_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_uart_dump.sv
module tb_ram_uart_dump;
  localparam int CPB   = 4;
  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int DEPTH = 64;
`ifdef RAM_DUMP_HEX_EN
  localparam int BPW = 6;
`else
  localparam int BPW = 2;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] ram_addr;
  logic          ram_rd_en;
  logic [DW-1:0] ram_data;
  logic          tx, busy, done;

  ram_uart_dump #(
    .CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DUMP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ram_addr(ram_addr),
    .ram_rd_en(ram_rd_en), .ram_data(ram_data), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [DW-1:0] mem [DEPTH];
  int            rd_q [$];
  logic [7:0]    rx_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // RAM: valid data only the cycle after a read, noise otherwise.
  always @(posedge clk) ram_data <= ram_rd_en ? mem[ram_addr] : DW'($urandom);

  always @(negedge clk) if (ram_rd_en) rd_q.push_back(int'(ram_addr));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // UART receiver: mid-bit sampling; a frame overlapping reset is dropped.
  always begin : rx_mon
    logic [7:0] b;
    logic       ok;
    @(negedge clk);
    if (reset && tx === 1'b0) begin
      ok = 1'b1;
      repeat (CPB + CPB / 2) begin @(negedge clk); if (!reset) ok = 1'b0; end
      for (int k = 0; k < 8; k++) begin
        b[k] = tx;
        repeat (CPB) begin @(negedge clk); if (!reset) ok = 1'b0; end
      end
      if (ok) begin
        chk("stop_bit", 32'(tx), 32'd1);
        rx_q.push_back(b);
      end
    end
  end

  task automatic run_dump();
    logic [7:0] ex [$];
    int e, tgt, t, ones;
`ifdef RAM_DUMP_HEX_EN
    string hexd = "0123456789ABCDEF";
`endif
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    mem[0] = 16'h00F3;
    mem[1] = 16'hA55A;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef RAM_DUMP_HEX_EN
      for (int n = 3; n >= 0; n--) ex.push_back(hexd[(int'(mem[i]) >> (4 * n)) & 15]);
      ex.push_back(8'h0D);
      ex.push_back(8'h0A);
`else
      ex.push_back(8'(mem[i] >> 8));
      ex.push_back(8'(mem[i]));
`endif
    end
    rd_q.delete();
    rx_q.delete();

    @(negedge clk);
    start = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    chk("rd_en_first", 32'(ram_rd_en), 32'd1);
    chk("addr_first", 32'(ram_addr), 32'd0);
    chk("busy_run", 32'(busy), 32'd1);
    @(negedge clk);
    chk("rd_en_pulse", 32'(ram_rd_en), 32'd0);
    repeat (2) @(negedge clk);
    chk("tx_start_bit", 32'(tx), 32'd0);

    tgt = e + DEPTH * (41 * BPW + 2);
    t = 0;
    while (!done && t < 30000) begin
      @(negedge clk);
      t++;
      start = (cyc - e < 800) ? 1'($urandom) : 1'b1;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    else       chk("done_cycle", 32'(cyc), 32'(tgt));
    chk("busy_at_done", 32'(busy), 32'd0);

    ones = 0;
    repeat (6) begin @(negedge clk); ones += int'(done); end
    chk("done_held", 32'(ones), 32'd6);
    chk("tx_idle_done", 32'(tx), 32'd1);

    chk("rd_count", 32'(rd_q.size()), 32'(DEPTH));
    for (int i = 0; i < rd_q.size() && i < DEPTH; i++) chk("rd_addr", 32'(rd_q[i]), 32'(i));
    chk("rx_count", 32'(rx_q.size()), 32'(ex.size()));
    for (int i = 0; i < rx_q.size() && i < ex.size(); i++) chk("rx_byte", 32'(rx_q[i]), 32'(ex[i]));
  endtask

  initial begin
    int t;
    reset = 1'b0;
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
      chk("rst_addr", 32'(ram_addr), 32'd0);
    end
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    run_dump();

    // re-arm
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rearm_done_low", 32'(done), 32'd0);
    chk("rearm_busy_low", 32'(busy), 32'd0);
    run_dump();

    // reset during the data bits of word 3
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    t = 0;
    while (!(ram_rd_en && ram_addr == AW'(3)) && t < 5000) begin @(negedge clk); t++; end
    chk("reach_word3", 32'(ram_rd_en && ram_addr == AW'(3)), 32'd1);
    repeat (10) @(negedge clk);
    chk("mid_in_data", 32'(busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_addr", 32'(ram_addr), 32'd0);
    start = 1'b0;
    reset = 1'b1;
    repeat (50) @(negedge clk);
    chk("post_rst_idle_tx", 32'(tx), 32'd1);
    run_dump();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
